// File: rtl/add_sub_arbiter.sv
// Round-robin arbiter sharing one add_subBar unit between two valid/ready
// requesters; results return on a single registered, ID-tagged response channel.

module add_subBar #(
  parameter int n = 4
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         add_sub,
  output logic [n-1:0] s,
  output logic         cout,
  output logic         OverflowSign
);
  logic [n-1:0] bx;
  logic [n:0]   sum;

  // add_sub = 1 subtracts: A + ~B + 1
  always_comb begin
    bx  = b ^ {n{add_sub}};
    sum = {1'b0, a} + {1'b0, bx} + {{n{1'b0}}, add_sub};
  end

  assign s            = sum[n-1:0];
  assign cout         = sum[n];
  assign OverflowSign = (a[n-1] == bx[n-1]) && (s[n-1] != a[n-1]);
endmodule

module add_sub_arbiter #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [n-1:0] req0_a,
  input  logic [n-1:0] req0_b,
  input  logic         req0_sub,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [n-1:0] req1_a,
  input  logic [n-1:0] req1_b,
  input  logic         req1_sub,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [n-1:0] rsp_s,
  output logic         rsp_cout,
  output logic         rsp_ovf,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t       state_q, state_d;
  logic         last_grant_q;
  logic [n-1:0] op_a_q, op_b_q;
  logic         op_sub_q, op_id_q;
  logic [n-1:0] rsp_s_q;
  logic         rsp_cout_q, rsp_ovf_q, rsp_id_q;

  logic         gnt_any, gnt_id, accept;
  logic [n-1:0] unit_s, op_bx;
  logic         unit_cout, unit_ovf_unused;

  add_subBar #(.n(n)) u_unit (
    .a            (op_a_q),
    .b            (op_b_q),
    .add_sub      (op_sub_q),
    .s            (unit_s),
    .cout         (unit_cout),
    .OverflowSign (unit_ovf_unused)
  );

  // Contention goes to whichever requester was not granted last
  always_comb begin
    gnt_any = req0_valid || req1_valid;
    gnt_id  = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    accept  = (state_q == IDLE) && gnt_any;
    op_bx   = op_b_q ^ {n{op_sub_q}};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_sub_q     <= 1'b0;
      op_id_q      <= 1'b0;
      rsp_s_q      <= '0;
      rsp_cout_q   <= 1'b0;
      rsp_ovf_q    <= 1'b0;
      rsp_id_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_a_q       <= gnt_id ? req1_a : req0_a;
        op_b_q       <= gnt_id ? req1_b : req0_b;
        op_sub_q     <= gnt_id ? req1_sub : req0_sub;
        op_id_q      <= gnt_id;
        last_grant_q <= gnt_id;
      end
      if (state_q == EXEC) begin
        rsp_s_q    <= unit_s;
        rsp_cout_q <= unit_cout;
        rsp_ovf_q  <= (op_a_q[n-1] == op_bx[n-1]) && (unit_s[n-1] != op_a_q[n-1]);
        rsp_id_q   <= op_id_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_any) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = (state_q == IDLE) && gnt_any && !gnt_id;
    req1_ready = (state_q == IDLE) && gnt_any && gnt_id;
    rsp_valid  = (state_q == RESP);
    busy       = (state_q != IDLE);
    rsp_id     = rsp_id_q;
    rsp_s      = rsp_s_q;
    rsp_cout   = rsp_cout_q;
    rsp_ovf    = rsp_ovf_q;
  end
endmodule

// File: tb/tb_add_sub_arbiter.sv
// Scoreboard bench for add_sub_arbiter: a transaction-level model predicts
// grants and results; a monitor checks each response handshake against the queue.

module tb_add_sub_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, req0_sub;
  logic [3:0] req0_a, req0_b;
  logic       req1_valid, req1_ready, req1_sub;
  logic [3:0] req1_a, req1_b;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_ovf, busy;
  logic [3:0] rsp_s;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       id;
    logic [3:0] s;
    logic       cout;
    logic       ovf;
  } rsp_t;

  rsp_t exp_q[$];

  // Model state: phase 0 = free, 1 = computing, 2 = holding a response
  int   m_phase = 0;
  bit   m_last  = 1'b1;
  bit   done    = 1'b0;

  always #5 clk = ~clk;

  add_sub_arbiter #(.n(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_sub(req1_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_s(rsp_s), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf), .busy(busy)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sval(input logic [3:0] v);
    return v[3] ? int'(v) - 16 : int'(v);
  endfunction

  // Plain arithmetic reference: modular result, unsigned carry / no-borrow, signed range
  function automatic rsp_t model(input bit id, input logic [3:0] a, input logic [3:0] b, input bit sub);
    rsp_t r;
    int   u, sr;
    u  = sub ? int'(a) - int'(b) : int'(a) + int'(b);
    sr = sub ? sval(a) - sval(b) : sval(a) + sval(b);
    r.id   = id;
    r.s    = 4'((u + 16) % 16);
    r.cout = sub ? (int'(a) >= int'(b)) : (u >= 16);
    r.ovf  = (sr > 7) || (sr < -8);
    return r;
  endfunction

  // One clock cycle: drive at the falling edge, check handshake outputs, advance the model
  task automatic cycle(input bit v0, input logic [3:0] a0, input logic [3:0] b0, input bit s0,
                       input bit v1, input logic [3:0] a1, input logic [3:0] b1, input bit s1,
                       input bit rr, output bit g0, output bit g1);
    bit gv, gid;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_sub = s0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_sub = s1;
    rsp_ready  = rr;
    #1;
    gv  = (m_phase == 0) && (v0 || v1);
    gid = (v0 && v1) ? !m_last : v1;
    g0  = gv && !gid;
    g1  = gv && gid;
    check("req0_ready", {7'b0, req0_ready}, {7'b0, g0});
    check("req1_ready", {7'b0, req1_ready}, {7'b0, g1});
    check("busy", {7'b0, busy}, {7'b0, m_phase != 0});
    check("rsp_valid", {7'b0, rsp_valid}, {7'b0, m_phase == 2});
    if (gv) begin
      exp_q.push_back(gid ? model(1'b1, a1, b1, s1) : model(1'b0, a0, b0, s0));
      m_last  = gid;
      m_phase = 1;
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (m_phase == 2 && rr) begin
      m_phase = 0;
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit rr);
    bit g0, g1;
    cycle(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, rr, g0, g1);
  endtask

  task automatic check_reset_outputs();
    check("rst_rsp_valid", {7'b0, rsp_valid}, 8'h0);
    check("rst_busy", {7'b0, busy}, 8'h0);
    check("rst_rsp", {1'b0, rsp_id, rsp_s, rsp_cout, rsp_ovf}, 8'h0);
  endtask

  // Monitor: compares every completed response handshake and response stability under backpressure
  initial begin : monitor
    rsp_t       got, exp;
    bit         hold = 1'b0;
    rsp_t       held;
    while (!done) begin
      @(negedge clk);
      #2;
      got = '{id: rsp_id, s: rsp_s, cout: rsp_cout, ovf: rsp_ovf};
      if (hold && rsp_valid)
        check("rsp_stable", {1'b0, got}, {1'b0, held});
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 8'h1, 8'h0);
        end else begin
          exp = exp_q.pop_front();
          check("rsp_id", {7'b0, got.id}, {7'b0, exp.id});
          check("rsp_s", {4'b0, got.s}, {4'b0, exp.s});
          check("rsp_cout", {7'b0, got.cout}, {7'b0, exp.cout});
          check("rsp_ovf", {7'b0, got.ovf}, {7'b0, exp.ovf});
        end
      end
      hold = rsp_valid && !rsp_ready && rst_n;
      held = got;
    end
  end

  initial begin : driver
    bit         g0, g1;
    bit         p0, p1, ps0, ps1;
    logic [3:0] pa0, pb0, pa1, pb1;
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
    rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reset_outputs();
    @(negedge clk);

    // Contention from reset: grants alternate starting with requester 0
    for (int i = 0; i < 12; i++)
      cycle(1'b1, 4'h2, 4'h3, 1'b0, 1'b1, 4'h9, 4'h4, 1'b1, 1'b1, g0, g1);

    // Directed arithmetic cases
    cycle(1'b1, 4'b0101, 4'b0011, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, g0, g1);
    idle(1'b1); idle(1'b1);
    cycle(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'b0011, 4'b0101, 1'b1, 1'b1, g0, g1);
    idle(1'b1); idle(1'b1);
    cycle(1'b1, 4'b0111, 4'b1000, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, g0, g1);
    idle(1'b1); idle(1'b1);
    cycle(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'b1000, 4'b0001, 1'b1, 1'b1, g0, g1);
    idle(1'b1); idle(1'b1);
    cycle(1'b1, 4'b1111, 4'b0001, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, g0, g1);
    idle(1'b1); idle(1'b1);
    cycle(1'b1, 4'b0110, 4'b0000, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, g0, g1);
    idle(1'b1); idle(1'b1);

    // Response backpressure for four cycles in RESP
    cycle(1'b1, 4'b1100, 4'b1011, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, g0, g1);
    idle(1'b0);
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 4'h1, 4'h1, 1'b0, 1'b1, 4'h2, 4'h2, 1'b0, 1'b0, g0, g1);
    idle(1'b1);
    idle(1'b1);

    // Reset during EXEC discards the operation and restores requester-0 priority
    cycle(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'h5, 4'h6, 1'b0, 1'b1, g0, g1);
    rst_n = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    void'(exp_q.pop_back());
    m_phase = 0;
    m_last  = 1'b1;
    #1;
    check_reset_outputs();
    @(negedge clk);
    for (int i = 0; i < 6; i++)
      cycle(1'b1, 4'h7, 4'h7, 1'b0, 1'b1, 4'h8, 4'h8, 1'b1, 1'b1, g0, g1);

    // Randomized traffic; pending requests hold operands until granted, occasionally withdrawn
    p0 = 1'b0; p1 = 1'b0;
    pa0 = '0; pb0 = '0; ps0 = 1'b0; pa1 = '0; pb1 = '0; ps1 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!p0 || $urandom_range(0, 7) == 0) begin
        p0 = ($urandom_range(0, 2) != 0);
        pa0 = 4'($urandom); pb0 = 4'($urandom); ps0 = 1'($urandom);
      end
      if (!p1 || $urandom_range(0, 7) == 0) begin
        p1 = ($urandom_range(0, 2) != 0);
        pa1 = 4'($urandom); pb1 = 4'($urandom); ps1 = 1'($urandom);
      end
      cycle(p0, pa0, pb0, ps0, p1, pa1, pb1, ps1, ($urandom_range(0, 3) != 0), g0, g1);
      if (g0) p0 = 1'b0;
      if (g1) p1 = 1'b0;
    end

    for (int i = 0; i < 4; i++) idle(1'b1);
    check("queue_drained", 8'(exp_q.size()), 8'h0);
    done = 1'b1;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
